// File: rtl/aes_shiftrows_buffer.sv
// aes_shiftrows_buffer
// Column-serial ShiftRows / InvShiftRows stage for a 32-bit AES round datapath.
// The stage collects the four 32-bit columns of one state, then emits the
// byte-permuted columns one per output transfer.
//
// Ports:
//   clk, rst           rising-edge clock, synchronous active-high reset
//   in_valid/in_ready  input column handshake
//   in_data            state column, row r byte at [8r+7:8r]
//   in_enc_dec         1 = ShiftRows, 0 = InvShiftRows (taken from column 0)
//   out_valid/out_ready output column handshake
//   out_data           permuted column, same byte layout as in_data
//   out_col            index of the column on out_data
//   out_last           high with column 3
//
// Build option: define AES_SHIFTROWS_PINGPONG_EN for two buffer banks, so one
// block can fill while the previous block drains.
module aes_shiftrows_buffer #(
  parameter int NUM_COLS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_enc_dec,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [1:0]  out_col,
  output logic        out_last
);

  // Output column col, row r takes row r of column col+r (encrypt) or col-r
  // (decrypt). The 2-bit index wraps naturally, so this is pure byte routing.
  function automatic logic [31:0] permute(input logic [NUM_COLS-1:0][31:0] blk,
                                          input logic mode,
                                          input logic [1:0] col);
    logic [31:0] res;
    logic [1:0]  src;
    res = 32'h0000_0000;
    for (int r = 0; r < NUM_COLS; r++) begin
      if (mode) begin
        src = col + 2'(r);
      end else begin
        src = col - 2'(r);
      end
      res[8*r +: 8] = blk[src][8*r +: 8];
    end
    return res;
  endfunction

  logic [1:0] fill_cnt_r;
  logic [1:0] drain_cnt_r;
  logic       in_ready_r;
  logic       out_valid_r;
  logic       in_fire_s;
  logic       out_fire_s;

  assign in_fire_s  = in_valid & in_ready_r;
  assign out_fire_s = out_valid_r & out_ready;

`ifdef AES_SHIFTROWS_PINGPONG_EN

  logic [1:0][NUM_COLS-1:0][31:0] col_buf_r;
  logic [1:0] mode_r;
  logic [1:0] full_r;
  logic [1:0] full_s;
  logic       fill_bank_r;
  logic       fill_bank_s;
  logic       drain_bank_r;
  logic       drain_bank_s;

  // Bank occupancy: a bank becomes full on its 4th column and empties on its
  // 4th drained column. Both can happen in one cycle only on different banks.
  always_comb begin
    full_s       = full_r;
    fill_bank_s  = fill_bank_r;
    drain_bank_s = drain_bank_r;
    if (in_fire_s && (fill_cnt_r == 2'd3)) begin
      full_s[fill_bank_r] = 1'b1;
      fill_bank_s         = ~fill_bank_r;
    end else begin
      fill_bank_s = fill_bank_r;
    end
    if (out_fire_s && (drain_cnt_r == 2'd3)) begin
      full_s[drain_bank_r] = 1'b0;
      drain_bank_s         = ~drain_bank_r;
    end else begin
      drain_bank_s = drain_bank_r;
    end
  end

  // Control registers; handshake outputs are registered from next-cycle occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      full_r       <= 2'b00;
      fill_bank_r  <= 1'b0;
      drain_bank_r <= 1'b0;
      fill_cnt_r   <= 2'd0;
      drain_cnt_r  <= 2'd0;
      mode_r       <= 2'b11;
      in_ready_r   <= 1'b0;
      out_valid_r  <= 1'b0;
    end else begin
      full_r       <= full_s;
      fill_bank_r  <= fill_bank_s;
      drain_bank_r <= drain_bank_s;
      in_ready_r   <= ~full_s[fill_bank_s];
      out_valid_r  <= full_s[drain_bank_s];
      if (in_fire_s) begin
        fill_cnt_r <= fill_cnt_r + 2'd1;
        if (fill_cnt_r == 2'd0) begin
          mode_r[fill_bank_r] <= in_enc_dec;
        end
      end
      if (out_fire_s) begin
        drain_cnt_r <= drain_cnt_r + 2'd1;
      end
    end
  end

  // Column storage needs no reset; contents are only read once a bank is full.
  always_ff @(posedge clk) begin
    if (in_fire_s) begin
      col_buf_r[fill_bank_r][fill_cnt_r] <= in_data;
    end
  end

  assign out_data = permute(col_buf_r[drain_bank_r], mode_r[drain_bank_r], drain_cnt_r);

`else

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t state_r;
  state_t state_s;
  logic [NUM_COLS-1:0][31:0] col_buf_r;
  logic mode_r;

  // Next-state logic: the 4th accepted column starts the drain, the 4th
  // drained column returns to filling.
  always_comb begin
    state_s = state_r;
    case (state_r)
      FILL: begin
        if (in_fire_s && (fill_cnt_r == 2'd3)) begin
          state_s = DRAIN;
        end else begin
          state_s = FILL;
        end
      end
      DRAIN: begin
        if (out_fire_s && (drain_cnt_r == 2'd3)) begin
          state_s = FILL;
        end else begin
          state_s = DRAIN;
        end
      end
      default: state_s = FILL;
    endcase
  end

  // State and counters; handshake outputs are registered from the next state
  // so out_valid rises in the cycle right after the 4th column is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= FILL;
      fill_cnt_r  <= 2'd0;
      drain_cnt_r <= 2'd0;
      mode_r      <= 1'b1;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      in_ready_r  <= (state_s == FILL);
      out_valid_r <= (state_s == DRAIN);
      if (in_fire_s) begin
        fill_cnt_r <= fill_cnt_r + 2'd1;
        if (fill_cnt_r == 2'd0) begin
          mode_r <= in_enc_dec;
        end
      end
      if (out_fire_s) begin
        drain_cnt_r <= drain_cnt_r + 2'd1;
      end
    end
  end

  // Column storage needs no reset; contents are only read while draining.
  always_ff @(posedge clk) begin
    if (in_fire_s) begin
      col_buf_r[fill_cnt_r] <= in_data;
    end
  end

  assign out_data = permute(col_buf_r, mode_r, drain_cnt_r);

`endif

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_col   = drain_cnt_r;
  assign out_last  = (drain_cnt_r == 2'd3);

endmodule

// File: doc/aes_shiftrows_buffer.md
Name: aes_shiftrows_buffer

Overview:
- Column-serial ShiftRows / InvShiftRows stage. It sits directly downstream of the 32-bit SubBytes stage in the 32-bit AES round datapath.
- Collects the four 32-bit state columns of one block, permutes the bytes across columns per enc_dec, then emits four permuted columns to the next round stage.
- Valid/ready handshake on both sides; one block in flight per buffer bank.

Parameters:
- NUM_COLS, 4, columns per AES state. Fixed at 4; any other value is unsupported.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset (synchronous, active-high)
- in_valid  input  1  in_data/in_enc_dec valid
- in_ready  output  1  stage can accept a column
- in_data  input  32  state column; row r byte at bits [8r+7:8r], row 0 at LSB
- in_enc_dec  input  1  1=ShiftRows (encrypt), 0=InvShiftRows (decrypt); sampled on column 0 only
- out_valid  output  1  out_data valid
- out_ready  input  1  downstream accepts
- out_data  output  32  permuted column, same byte layout as in_data
- out_col  output  2  index of the column on out_data (0..3)
- out_last  output  1  high with column 3

Behaviour:
- Clock/reset: one clock, clk. Reset is synchronous and active-high on rst.
- Transfers: an input transfer occurs when in_valid & in_ready. An output transfer occurs when out_valid & out_ready.
- Storage: 4x32-bit column buffer, 2-bit fill counter, 2-bit drain counter, 1-bit captured mode, state register.
- States:
  - FILL: in_ready=1, out_valid=0. Each input transfer writes in_data to buf[fill_cnt] and increments fill_cnt. The transfer at fill_cnt=0 also latches mode=in_enc_dec. The transfer at fill_cnt=3 wraps fill_cnt to 0 and goes to DRAIN.
  - DRAIN: in_ready=0, out_valid=1. Each output transfer increments drain_cnt. The transfer at drain_cnt=3 wraps drain_cnt to 0 and goes to FILL.
- Permutation, out column c, row r:
  - mode=1: buf[(c+r) mod 4] row r.
  - mode=0: buf[(c-r) mod 4] row r.
  - Pure byte routing from registers; no arithmetic.
- Output signals: out_data is driven from the buffer registers via the permutation mux for column drain_cnt. out_col=drain_cnt. out_last=(drain_cnt==3).
- Latency: column 3 accepted in cycle N -> out_valid=1 with column 0 in cycle N+1. Minimum block period is 8 cycles (4 fill + 4 drain).
- Stalls:
  - out_ready low holds out_data, out_col and out_last stable.
  - in_valid gaps during FILL simply pause the fill counter.
- in_enc_dec on columns 1..3 is ignored. A mode change mid-block has no effect.
- Reset values: state=FILL, fill_cnt=0, drain_cnt=0, mode=1, in_ready=0 during the reset cycle then 1, out_valid=0, out_col=0, out_last=0. Buffer contents are don't-care.
- Reset mid-operation: partial block discarded, no output produced. An in-flight drain is aborted and out_valid drops in the cycle after rst is sampled.
- Simultaneous events: in FILL, in_ready is independent of out_ready. In DRAIN, input is never accepted even if in_valid=1.

Optional Feature:
- Macro: AES_SHIFTROWS_PINGPONG_EN
- Defined:
  - Two buffer banks, each with its own captured mode.
  - Fill bank and drain bank are tracked independently, so a block can fill while the previous one drains.
  - in_ready=0 only when both banks hold complete undrained blocks.
  - Sustained throughput is 1 column/cycle. Latency is unchanged (N+1).
  - Blocks are output in arrival order.
- Undefined: single bank, FILL/DRAIN behaviour as above.

Test Plan:
- FIPS-197 round-1 encrypt: in_enc_dec=1, columns 0xae1127d4, 0xf198bfe0, 0xe55db4b8, 0x3052411e -> outputs 0x305dbfd4, 0xae52b4e0, 0xf11141b8, 0xe598271e; out_col 0..3; out_last only on the 4th; first out_valid one cycle after the 4th accept.
- Inverse: in_enc_dec=0, columns 0x305dbfd4, 0xae52b4e0, 0xf11141b8, 0xe598271e -> 0xae1127d4, 0xf198bfe0, 0xe55db4b8, 0x3052411e.
- Backpressure: out_ready low for 5 cycles on column 1 -> out_data holds 0xae52b4e0, in_ready stays 0, no column skipped or repeated.
- Mode sampling: in_enc_dec=1 on column 0, then 0 on columns 1..3 with the encrypt vector -> output equals the encrypt result.
- Reset mid-fill after 2 columns, then a full new block -> output matches only the new block; out_valid stays 0 until 4 new columns are accepted.
- With AES_SHIFTROWS_PINGPONG_EN and out_ready=1: 3 back-to-back blocks -> in_ready never drops, 12 consecutive output beats, correct per-block mode.
